sd_block_reader: RTL and testbench

Downstream data stage of the SD-over-SPI path. After `sd_control` issues CMD17 and receives R1 = 0x00, it pulses `start`. This block then does three things: hunts for the data start token on D0, shifts in one BLOCK_BYTES data block MSB-first, and checks the trailing CRC16. Received bytes are presented as a one-byte-per-strobe stream to the buffer/consumer above.

---
 rtl/sd_pkg.sv | 28 ++
 rtl/sd_crc16_serial.sv | 28 ++
 rtl/sd_block_reader.sv | 168 ++++++++++++++++
 tb/tb_sd_block_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared SD-over-SPI definitions: read-path state and error encodings,
// token/polynomial constants and the one-bit CRC16 step.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TOKEN,
        DATA,
        CRC,
        FINISH
    } sd_rd_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_TOKEN   = 2'd2,
        ERR_CRC     = 2'd3
    } sd_rd_err_t;

    localparam logic [7:0]  SD_TOKEN_START = 8'hFE;
    localparam logic [15:0] SD_CRC16_POLY  = 16'h1021;

    // One serial CRC16 step (MSB-first, no reflection), overflow discarded.
    function automatic logic [15:0] sd_crc16_next(input logic [15:0] crc, input logic bit_in);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? SD_CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// Serial CRC16 (x^16+x^12+x^5+1, init 0): absorbs one bit per enabled cycle.
// Shared between the block read path and the future write path.
module sd_crc16_serial
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    // CRC register: cleared on reset or request, otherwise advances one bit when enabled.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_crc <= 16'h0000;
        end else if (en) begin
            r_crc <= sd_crc16_next(r_crc, bit_in);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/sd_block_reader.sv
// sd_block_reader: after a start pulse, hunts for the data start token on D0,
// shifts in one block MSB-first as a byte stream and checks the trailing CRC16.
module sd_block_reader
    import sd_pkg::*;
#(
    parameter int BLOCK_BYTES   = 512,
    parameter int TOKEN_TIMEOUT = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           D0,
    output logic                           D1_hold,
    output logic                           busy,
    output logic [7:0]                     byte_data,
    output logic                           byte_valid,
    output logic [$clog2(BLOCK_BYTES)-1:0] byte_index,
    output logic                           done,
    output logic [1:0]                     error_code
);

    localparam int IDX_W = $clog2(BLOCK_BYTES);
    localparam int TO_W  = $clog2(TOKEN_TIMEOUT + 1);

    sd_rd_state_t     r_state;
    sd_rd_state_t     w_next_state;
    sd_rd_err_t       r_error;
    logic [6:0]       r_shift;
    logic [3:0]       r_bit_cnt;
    logic [IDX_W-1:0] r_byte_cnt;
    logic [IDX_W-1:0] r_byte_index;
    logic [TO_W-1:0]  r_timeout_cnt;
    logic [7:0]       r_byte_data;
    logic             r_byte_valid;

    logic [7:0]       w_byte;
    logic             w_accept;
    logic             w_byte_end;
    logic             w_crc_end;
    logic             w_last_byte;
    logic             w_err_token;
    logic             w_timeout_hit;
    logic             w_crc_en;
    logic [15:0]      w_crc;
    logic [15:0]      w_crc_next;

    // Byte assembled from the seven earlier bits plus the bit on D0 this edge.
    assign w_byte        = {r_shift, D0};
    assign w_accept      = (r_state == IDLE) && start;
    assign w_byte_end    = (r_bit_cnt[2:0] == 3'd7);
    assign w_crc_end     = (r_bit_cnt == 4'd15);
    assign w_last_byte   = (r_byte_cnt == IDX_W'(BLOCK_BYTES - 1));
    assign w_err_token   = (w_byte[7:4] == 4'h0) && (w_byte != 8'h00);
    assign w_timeout_hit = (r_timeout_cnt == TO_W'(TOKEN_TIMEOUT - 1));
    assign w_crc_en      = (r_state == DATA) || (r_state == CRC);
    // Residue including the bit being sampled now, so the verdict lands with the last CRC bit.
    assign w_crc_next    = sd_crc16_next(w_crc, D0);

    sd_crc16_serial u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_accept),
        .en     (w_crc_en),
        .bit_in (D0),
        .crc    (w_crc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; done is a pure decode of FINISH so a start in that cycle is ignored.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = TOKEN;
            end
            TOKEN: begin
                if (w_byte_end) begin
                    if (w_byte == SD_TOKEN_START) w_next_state = DATA;
                    else if (w_err_token)         w_next_state = FINISH;
                    else if (w_timeout_hit)       w_next_state = FINISH;
                end
            end
            DATA: begin
                if (w_byte_end && w_last_byte) w_next_state = CRC;
            end
            CRC: begin
                if (w_crc_end) w_next_state = FINISH;
            end
            FINISH: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: shift register, bit/byte/timeout counters, byte strobe and error code.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_timeout_cnt <= '0;
            r_byte_data   <= '0;
            r_byte_index  <= '0;
            r_byte_valid  <= 1'b0;
            r_error       <= ERR_NONE;
        end else begin
            r_byte_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift       <= '0;
                        r_bit_cnt     <= '0;
                        r_byte_cnt    <= '0;
                        r_timeout_cnt <= '0;
                        r_error       <= ERR_NONE;
                    end
                end
                TOKEN: begin
                    r_shift   <= w_byte[6:0];
                    r_bit_cnt <= {1'b0, r_bit_cnt[2:0] + 3'd1};
                    if (w_byte_end && (w_byte != SD_TOKEN_START)) begin
                        if (w_err_token) begin
                            r_error <= ERR_TOKEN;
                        end else begin
                            r_timeout_cnt <= r_timeout_cnt + TO_W'(1);
                            if (w_timeout_hit) r_error <= ERR_TIMEOUT;
                        end
                    end
                end
                DATA: begin
                    r_shift   <= w_byte[6:0];
                    r_bit_cnt <= {1'b0, r_bit_cnt[2:0] + 3'd1};
                    if (w_byte_end) begin
                        r_byte_valid <= 1'b1;
                        r_byte_data  <= w_byte;
                        r_byte_index <= r_byte_cnt;
                        r_byte_cnt   <= r_byte_cnt + IDX_W'(1);
                    end
                end
                CRC: begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (w_crc_end) r_error <= (w_crc_next != 16'h0000) ? ERR_CRC : ERR_NONE;
                end
                default: ;
            endcase
        end
    end

    assign D1_hold    = 1'b1;
    assign busy       = (r_state != IDLE);
    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign byte_index = r_byte_index;
    assign error_code = r_error;

endmodule

// File: tb/tb_sd_block_reader.sv
// Scoreboard bench for sd_block_reader: a reference model parses each D0 byte
// stream and queues the expected strobes and completion; a negedge monitor compares.
module tb_sd_block_reader;

    localparam int BB     = 512;
    localparam int TT     = 16;
    localparam int IW     = $clog2(BB);
    localparam int BUDGET = 6000;

    typedef struct {
        logic [7:0]    data;
        logic [IW-1:0] index;
    } exp_byte_t;

    typedef struct {
        logic [1:0] err;
        int         latency;
    } exp_done_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          D0;
    logic          D1_hold;
    logic          busy;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic [IW-1:0] byte_index;
    logic          done;
    logic [1:0]    error_code;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_strobe_cyc = 0;

    exp_byte_t  exp_bytes[$];
    exp_done_t  exp_done[$];
    logic [7:0] stream[$];

    sd_block_reader #(.BLOCK_BYTES(BB), .TOKEN_TIMEOUT(TT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .D0         (D0),
        .D1_hold    (D1_hold),
        .busy       (busy),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_index (byte_index),
        .done       (done),
        .error_code (error_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] byte_at(input logic [7:0] s[$], input int i);
        return (i < s.size()) ? s[i] : 8'hFF;
    endfunction

    // Byte-wise CRC16/XMODEM: poly 0x1021, init 0.
    function automatic logic [15:0] crc16_bytes(input logic [7:0] b[$]);
        logic [15:0] c = 16'h0000;
        foreach (b[i]) begin
            c = c ^ {b[i], 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // Parse a byte stream as the card would present it (idle 0xFF after its end).
    // Latency counts cycles inclusively from the start cycle to the done cycle.
    task automatic predict(input logic [7:0] s[$], output logic [1:0] err);
        int         pos = 0;
        int         misses = 0;
        bit         found = 0;
        logic [7:0] b;
        logic [7:0] blk[$];
        exp_done_t  d;
        exp_byte_t  e;
        while (!found && misses < TT) begin
            b = byte_at(s, pos);
            if (b == 8'hFE) begin
                found = 1;
            end else if (b inside {[8'h01:8'h0F]}) begin
                d.err = 2'd2; d.latency = 8 * (pos + 1) + 2;
                exp_done.push_back(d); err = d.err;
                return;
            end else begin
                misses++; pos++;
            end
        end
        if (!found) begin
            d.err = 2'd1; d.latency = 8 * TT + 2;
            exp_done.push_back(d); err = d.err;
            return;
        end
        for (int i = 0; i < BB; i++) begin
            e.data  = byte_at(s, pos + 1 + i);
            e.index = IW'(i);
            exp_bytes.push_back(e);
            blk.push_back(e.data);
        end
        blk.push_back(byte_at(s, pos + BB + 1));
        blk.push_back(byte_at(s, pos + BB + 2));
        d.err     = (crc16_bytes(blk) != 16'h0000) ? 2'd3 : 2'd0;
        d.latency = 8 * (pos + 1) + 8 * BB + 16 + 2;
        exp_done.push_back(d); err = d.err;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic make_prefix(input int k, input bit rnd);
        logic [7:0] v;
        stream.delete();
        for (int i = 0; i < k; i++) begin
            v = rnd ? 8'($urandom) : 8'hFF;
            if (v == 8'hFE || v inside {[8'h01:8'h0F]}) v = 8'hFF;
            stream.push_back(v);
        end
    endtask

    // Append token, data (pattern 0: i%256, else random) and CRC, optionally with one CRC bit flipped.
    task automatic add_block(input int pattern, input int flip_bit);
        logic [7:0]  blk[$];
        logic [7:0]  v;
        logic [15:0] c;
        stream.push_back(8'hFE);
        for (int i = 0; i < BB; i++) begin
            v = (pattern == 0) ? 8'(i) : 8'($urandom);
            blk.push_back(v);
            stream.push_back(v);
        end
        c = crc16_bytes(blk);
        if (flip_bit >= 0) c[flip_bit] = ~c[flip_bit];
        stream.push_back(c[15:8]);
        stream.push_back(c[7:0]);
    endtask

    // Pulse start, then play the stream MSB-first (stop_bits < 0: whole stream).
    task automatic play(input int mid_start, input int stop_bits);
        int nbits;
        nbits = (stop_bits >= 0) ? stop_bits : 8 * stream.size();
        @(negedge clk); start = 1'b1; start_cyc = cyc;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (done) break;
            D0    = stream[i / 8][7 - (i % 8)];
            start = (i == mid_start);
            @(negedge clk);
        end
        start = 1'b0;
        D0    = 1'b1;
    endtask

    task automatic finish_block(input logic [1:0] exp_err, input bit start_on_done);
        int budget = BUDGET;
        while (!done && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("done_within_budget", done, 1'b1);
        if (start_on_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_low_after_done", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("busy_stays_low", busy, 1'b0);
        check("error_code_held", error_code, exp_err);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_byte_t e;
        exp_done_t d;
        if (byte_valid) begin
            check("strobe_expected", exp_bytes.size() > 0, 1'b1);
            if (exp_bytes.size() > 0) begin
                e = exp_bytes.pop_front();
                check("byte_data", byte_data, e.data);
                check("byte_index", byte_index, e.index);
            end
            last_strobe_cyc = cyc;
        end
        if (done) begin
            check("done_expected", exp_done.size() > 0, 1'b1);
            if (exp_done.size() > 0) begin
                d = exp_done.pop_front();
                check("error_code", error_code, d.err);
                check("latency", cyc - start_cyc + 1, d.latency);
                check("all_strobes_before_done", exp_bytes.size(), 0);
                check("no_strobe_with_done", byte_valid, 1'b0);
                if (d.err == 2'd0 || d.err == 2'd3)
                    check("strobe_to_done_gap_ge16", (cyc - last_strobe_cyc) >= 16, 1'b1);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [1:0] err;
        reset = 1'b1;
        start = 1'b0;
        D0    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error_code", error_code, 2'd0);
        check("rst_byte_data", byte_data, 8'h00);
        check("rst_byte_index", byte_index, 0);
        check("rst_d1_hold", D1_hold, 1'b1);
        reset = 1'b0;
        @(negedge clk);

        // Token after three 0xFF, i%256 data, good CRC.
        make_prefix(3, 1'b0); add_block(0, -1); predict(stream, err);
        play(-1, -1); finish_block(err, 1'b0);

        // Same block, one CRC bit flipped.
        make_prefix(3, 1'b0); add_block(0, 5); predict(stream, err);
        play(-1, -1); finish_block(err, 1'b0);

        // Error token 0x09 after one 0xFF.
        stream.delete(); stream.push_back(8'hFF); stream.push_back(8'h09);
        predict(stream, err); play(-1, -1); finish_block(err, 1'b0);

        // D0 held high: token timeout.
        stream.delete(); predict(stream, err); play(-1, -1); finish_block(err, 1'b0);

        // Reset after byte 200 of DATA: 200 strobes, no done.
        make_prefix(3, 1'b0); add_block(0, -1); predict(stream, err);
        exp_done.delete();
        while (exp_bytes.size() > 200) void'(exp_bytes.pop_back());
        play(-1, 8 * (4 + 200));
        reset = 1'b1;
        @(negedge clk);
        check("reset_busy_low", busy, 1'b0);
        check("reset_no_done", done, 1'b0);
        reset = 1'b0;
        check("strobes_before_reset", exp_bytes.size(), 0);
        exp_bytes.delete();
        @(negedge clk);

        // Fresh block after reset; extra start pulses mid-DATA and on the done cycle.
        make_prefix(3, 1'b0); add_block(0, -1); predict(stream, err);
        play(1000, -1); finish_block(err, 1'b1);
        repeat (2 * 8 * TT) @(negedge clk);
        check("no_second_block", busy, 1'b0);

        // Randomised blocks: random prefix, good/corrupt CRC or error token.
        for (int r = 0; r < 4; r++) begin
            int kind;
            kind = $urandom_range(0, 3);
            make_prefix($urandom_range(0, 20), 1'b1);
            if (kind == 3) stream.push_back(8'($urandom_range(1, 15)));
            else           add_block(1, (kind == 2) ? $urandom_range(0, 15) : -1);
            predict(stream, err);
            play(-1, -1); finish_block(err, 1'b0);
        end

        check("scoreboard_drained", exp_bytes.size() + exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
